// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: zero-latency lookup, update on clock edge.
// No backpressure: upd_stall suppresses the update and any mispredict report for that cycle.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [29:0]      if_pc,
    output logic             pred_taken,
    output logic [29:0]      pred_target,
    input  logic             upd_valid,
    input  logic [29:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [29:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [29:0]      upd_pred_target,
    input  logic             upd_stall,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_RST   = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic             valid  [ENTRIES];
    logic [TAG_W-1:0] tag    [ENTRIES];
    logic [29:0]      target [ENTRIES];
    logic [CTR_W-1:0] ctr    [ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             do_upd;
    logic             unused_bits;

    assign l_idx = if_pc[IDX_W-1:0];
    assign l_tag = if_pc[IDX_W+TAG_W-1:IDX_W];
    assign l_hit = valid[l_idx] && (tag[l_idx] == l_tag);

    // Lookup sees pre-update contents; an update in the same cycle lands next cycle.
    assign pred_taken  = l_hit && ctr[l_idx][CTR_W-1];
    assign pred_target = pred_taken ? target[l_idx] : if_pc + 30'd1;

    assign u_idx  = upd_pc[IDX_W-1:0];
    assign u_tag  = upd_pc[IDX_W+TAG_W-1:IDX_W];
    assign u_hit  = valid[u_idx] && (tag[u_idx] == u_tag);
    assign do_upd = upd_valid && !upd_stall;

    assign mispredict = do_upd &&
        ((upd_taken != upd_pred_taken) ||
         (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

    assign unused_bits = ^{upd_pc, upd_pred_target};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= CTR_RST;
            end
            mispredict_cnt <= '0;
        end else begin
            if (do_upd) begin
                if (u_hit) begin
                    if (upd_taken && ctr[u_idx] != CTR_MAX)
                        ctr[u_idx] <= ctr[u_idx] + CTR_W'(1);
                    else if (!upd_taken && ctr[u_idx] != '0)
                        ctr[u_idx] <= ctr[u_idx] - CTR_W'(1);
                end else if (upd_taken) begin
                    valid[u_idx] <= 1'b1;
                    ctr[u_idx]   <= CTR_ALLOC;
                end
            end
            if (mispredict && mispredict_cnt != CNT_MAX)
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
        end
    end

    // Tag and target need no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (!rst && do_upd && upd_taken) begin
            tag[u_idx]    <= u_tag;
            target[u_idx] <= upd_target;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, TAG_W=8, CTR_W=2, CNT_W=2).
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] if_pc;
    logic        pred_taken;
    logic [29:0] pred_target;
    logic        upd_valid;
    logic [29:0] upd_pc;
    logic        upd_taken;
    logic [29:0] upd_target;
    logic        upd_pred_taken;
    logic [29:0] upd_pred_target;
    logic        upd_stall;
    logic        mispredict;
    logic [1:0]  mispredict_cnt;

    int checks = 0;
    int failures = 0;

    branch_predictor #(.ENTRIES(16), .TAG_W(8), .CTR_W(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .upd_stall(upd_stall),
        .mispredict(mispredict), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [29:0] pc, input logic tk, input logic [29:0] tgt,
                       input logic ptk, input logic [29:0] ptgt, input logic stall);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_target = ptgt; upd_stall = stall;
    endtask

    task automatic lookup(input string name, input logic [29:0] pc,
                          input logic exp_tk, input logic [29:0] exp_tgt);
        if_pc = pc;
        #1;
        chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        chk({name, "_target"}, {2'd0, pred_target}, {2'd0, exp_tgt});
    endtask

    initial begin
        rst = 1'b1; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; upd_stall = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // 1: reset state and PC+1 wrap
        lookup("rst_lookup", 30'h10, 1'b0, 30'h11);
        chk("rst_cnt", {30'd0, mispredict_cnt}, 32'd0);
        chk("idle_mispredict", {31'd0, mispredict}, 32'd0);
        lookup("wrap", 30'h3FFF_FFFF, 1'b0, 30'h0);

        // 2: allocate 0x10 -> 0x40; same-cycle lookup still sees the miss
        upd(30'h10, 1'b1, 30'h40, 1'b0, 30'h11, 1'b0);
        lookup("alloc_rdw", 30'h10, 1'b0, 30'h11);
        chk("alloc_mispredict", {31'd0, mispredict}, 32'd1);
        tick();
        upd_valid = 1'b0;
        lookup("alloc_hit", 30'h10, 1'b1, 30'h40);
        chk("alloc_cnt", {30'd0, mispredict_cnt}, 32'd1);

        // 3: ctr 2 -> 1 (predict not-taken), then floor at 0
        upd(30'h10, 1'b0, 30'h40, 1'b1, 30'h40, 1'b0);
        #1 chk("dir_mispredict", {31'd0, mispredict}, 32'd1);
        tick();
        upd_valid = 1'b0;
        lookup("dec1", 30'h10, 1'b0, 30'h11);
        chk("dec1_cnt", {30'd0, mispredict_cnt}, 32'd2);
        upd(30'h10, 1'b0, 30'h40, 1'b0, 30'h11, 1'b0);
        #1 chk("correct_nt_mispredict", {31'd0, mispredict}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        upd(30'h10, 1'b1, 30'h40, 1'b1, 30'h40, 1'b0);
        tick();
        upd_valid = 1'b0;
        lookup("floor_inc1", 30'h10, 1'b0, 30'h11);
        upd(30'h10, 1'b1, 30'h40, 1'b1, 30'h40, 1'b0);
        tick();
        upd_valid = 1'b0;
        lookup("inc2", 30'h10, 1'b1, 30'h40);
        upd(30'h10, 1'b1, 30'h40, 1'b1, 30'h40, 1'b0);
        tick();
        upd(30'h10, 1'b1, 30'h44, 1'b1, 30'h44, 1'b0);
        tick();
        upd(30'h10, 1'b0, 30'h44, 1'b0, 30'h11, 1'b0);
        tick();
        upd_valid = 1'b0;
        lookup("sat_then_dec", 30'h10, 1'b1, 30'h44);
        upd(30'h10, 1'b0, 30'h44, 1'b0, 30'h11, 1'b0);
        tick();
        upd_valid = 1'b0;
        lookup("sat_dec2", 30'h10, 1'b0, 30'h11);
        chk("sat_cnt", {30'd0, mispredict_cnt}, 32'd2);

        // 4: alias at index 0, wrong-target mispredict
        upd(30'h210, 1'b1, 30'h80, 1'b1, 30'h90, 1'b0);
        #1 chk("tgt_mispredict", {31'd0, mispredict}, 32'd1);
        tick();
        upd_valid = 1'b0;
        lookup("alias_old", 30'h10, 1'b0, 30'h11);
        lookup("alias_new", 30'h210, 1'b1, 30'h80);
        chk("alias_cnt", {30'd0, mispredict_cnt}, 32'd3);

        // 5: stalled update changes nothing; unstalled update read-during-write
        upd(30'h210, 1'b0, 30'h80, 1'b1, 30'h80, 1'b1);
        #1 chk("stall_mispredict", {31'd0, mispredict}, 32'd0);
        tick(); tick();
        upd_valid = 1'b0;
        lookup("stall_hold", 30'h210, 1'b1, 30'h80);
        chk("stall_cnt", {30'd0, mispredict_cnt}, 32'd3);
        upd(30'h210, 1'b0, 30'h80, 1'b0, 30'h211, 1'b0);
        lookup("rdw_old", 30'h210, 1'b1, 30'h80);
        tick();
        upd_valid = 1'b0;
        lookup("rdw_new", 30'h210, 1'b0, 30'h211);

        // 6: reset with simultaneous update, then counter saturation
        upd(30'h5, 1'b1, 30'h30, 1'b0, 30'h6, 1'b0);
        tick();
        upd_valid = 1'b0;
        lookup("idx5_alloc", 30'h5, 1'b1, 30'h30);
        rst = 1'b1;
        upd(30'h7, 1'b1, 30'h50, 1'b0, 30'h8, 1'b0);
        tick();
        rst = 1'b0;
        upd_valid = 1'b0;
        lookup("post_rst_5", 30'h5, 1'b0, 30'h6);
        lookup("post_rst_7", 30'h7, 1'b0, 30'h8);
        chk("post_rst_cnt", {30'd0, mispredict_cnt}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            upd(30'h7, 1'b0, 30'h50, 1'b1, 30'h50, 1'b0);
            #1 chk("cnt_mispredict", {31'd0, mispredict}, 32'd1);
            tick();
            upd_valid = 1'b0;
            #1 chk($sformatf("cnt_sat_%0d", i), {30'd0, mispredict_cnt}, (i > 3) ? 32'd3 : i);
        end
        lookup("miss_nt_nochange", 30'h7, 1'b0, 30'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
